alu_arbiter: RTL
================

# alu_arbiter

Shares one combinational `alu` instance between two requesters, such as the integer pipeline and an address-generation or multi-cycle helper. Each requester presents operands and an opcode on a valid/ready request channel. The arbiter grants the ALU round-robin and captures the result in a single-entry output register. It returns the result and the zero flag on the issuing requester's own valid/ready response channel.

## Interface
Parameters:
- `DATA_W`, 32: operand/result width; must match the ALU (32).
- `OP_W`, 4: opcode width.

Ports (clock and reset first; one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  synchronous active-low reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  DATA_W  operands.
- `req0_op`  in  OP_W  opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as above, for requester 1.
- `rsp0_valid`  out  1  result pending for requester 0.
- `rsp0_ready`  in  1  requester 0 takes result.
- `rsp0_result`  out  DATA_W  ALU result.
- `rsp0_zero`  out  1  result == 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_result`, `rsp1_zero`: same as above, for requester 1.
- `busy`  out  1  output slot occupied.

## Operation
- Opcodes and their results:
  - 0000: add.
  - 0010: sub.
  - 0100: and.
  - 0101: or.
  - 0110: xor.
  - 0111: nor.
  - 1010: signed greater-than, giving 1 or 0.
  - Any other opcode: result 0, zero=1. It is not an error.
- Arithmetic wraps modulo 2^32, with no carry or overflow output.
- State machine, two states:
  - EMPTY: slot free.
  - FULL: result held, with owner tag `own` (0/1).
- Slot can accept when `state==EMPTY` or (`state==FULL` and `rsp<own>_ready`). The `rsp<own>_ready` term is the same-cycle drain.
- Grant, evaluated only when the slot can accept:
  - One valid: that requester is granted.
  - Both valid: the requester not granted last (`last` register) is granted.
  - `req<g>_ready=1` for the granted requester only. Ready may depend combinationally on valid; valid must not depend on ready.
- On accept:
  - ALU result/zero and tag are registered.
  - State goes to FULL.
  - `last<=g`.
- In FULL, `rsp<own>_valid=1` and the other rsp valid is 0. Result and zero are stable until handshake.
- Drain without new accept: FULL→EMPTY.
- Drain with accept: stay FULL with the new owner/result.
- Requester contract: holds a, b, op stable while valid and not ready. The arbiter itself holds no copy before accept.
- Reset:
  - state=EMPTY, `last=1` (first contention goes to requester 0).
  - All rsp valid=0, result=0, zero=0, busy=0.
  - An in-flight result is discarded.

## Timing
- Latency: accept in cycle N → rsp_valid at N+1.
- Throughput: 1 op/cycle while the owner's rsp_ready is high.
- Backpressure: a stalled response blocks both requesters (single slot). Request readies are low until drain.
- Simultaneous accept and drain in one cycle is legal and required. No bubble is inserted.
- Reset asserted mid-stall: the next cycle shows EMPTY with all valids low. A requester still holding valid is granted on the first cycle after `rstn` rises.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode constants: `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_NOR`, `ALU_SGT`.
  - State enum `{ARB_EMPTY, ARB_FULL}`.
  - `DATA_W`/`OP_W` defaults.
- One sub-module: the existing `alu`, instantiated once.
- Operand mux, grant logic, slot register and FSM are inline in `alu_arbiter`.

## Test plan
- Basic ops:
  - req0 add 5+7 → next cycle rsp0_valid, result 12, zero 0.
  - req1 sub 3−3 → rsp1 result 0, zero 1.
- Contention: both valid continuously with rsp readies high → accepts alternate 0,1,0,1 starting with 0 after reset. One result per cycle, tags match.
- Backpressure: rsp0_ready low 3 cycles with req1 valid → rsp0 result held, req1_ready low. In the cycle rsp0_ready rises, req1 is accepted; rsp1_valid follows next cycle.
- Signed compare: op 1010, a=0xFFFFFFFF, b=1 → result 0, zero 1. a=1, b=0xFFFFFFFF → result 1.
- Illegal op 0001, a=9, b=9 → result 0, zero 1.
- Reset while FULL and stalled → next cycle all rsp valid 0, busy 0. After release, pending req0 is accepted immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings and arbiter state type.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_SGT = 4'b1010;

    typedef enum logic {
        ARB_EMPTY,
        ARB_FULL
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; unknown opcodes yield a zero result rather than an error.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SGT: result = {{(DATA_W-1){1'b0}}, ($signed(a) > $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a single-entry
// result slot returned on the issuing requester's own response channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              busy
);

    arb_state_e        state;
    arb_state_e        state_next;
    logic              own;
    logic              last;
    logic              drain;
    logic              can_accept;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;

    // Acceptance is masked during reset so a held request is only granted once rstn is high.
    always_comb begin
        drain      = (state == ARB_FULL) && (own ? rsp1_ready : rsp0_ready);
        can_accept = rstn && ((state == ARB_EMPTY) || drain);
        grant      = (req0_valid && req1_valid) ? ~last : req1_valid;
        accept     = can_accept && (req0_valid || req1_valid);
        state_next = state;
        if (accept) begin
            state_next = ARB_FULL;
        end else if (drain) begin
            state_next = ARB_EMPTY;
        end
    end

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign alu_a  = grant ? req1_a  : req0_a;
    assign alu_b  = grant ? req1_b  : req0_b;
    assign alu_op = grant ? req1_op : req0_op;

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ARB_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // last resets to 1 so the first contention is won by requester 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            own      <= 1'b0;
            last     <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            own      <= grant;
            last     <= grant;
            result_q <= alu_result;
            zero_q   <= alu_zero;
        end
    end

    assign busy        = (state == ARB_FULL);
    assign rsp0_valid  = busy && !own;
    assign rsp1_valid  = busy && own;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

endmodule
